// File: rtl/led_row_streamer_gen.sv
// Streams the rows of one frame from a frame BRAM as a valid/ready beat stream.
// Read requests are credit-limited so that the output FIFO never overflows.
module led_row_streamer_gen #(
   parameter int FRAME_SEL_WIDTH = 3,
   parameter int ROW_ADDR_WIDTH  = 5,
   parameter int NUM_ROWS        = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int RD_LATENCY      = 2,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     start,
   input  logic [FRAME_SEL_WIDTH-1:0]               frame_sel,
   input  logic                                     reverse,
   input  logic                                     abort,
   output logic                                     bram_rd_en,
   output logic [FRAME_SEL_WIDTH+ROW_ADDR_WIDTH-1:0] bram_rd_addr,
   input  logic [DATA_WIDTH-1:0]                    bram_rd_data,
   output logic                                     row_valid,
   input  logic                                     row_ready,
   output logic [ROW_ADDR_WIDTH-1:0]                row_idx,
   output logic [DATA_WIDTH-1:0]                    row_data,
   output logic                                     row_last,
   output logic                                     busy,
   output logic                                     done
);

   localparam int CW = $clog2(FIFO_DEPTH + RD_LATENCY + 1) + 1;
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int IW = ROW_ADDR_WIDTH + 1;
   localparam logic [IW-1:0] LAST_CNT = IW'(NUM_ROWS - 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
   localparam logic [PW-1:0] PTR_MAX  = PW'(FIFO_DEPTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_nxt;

   logic [FRAME_SEL_WIDTH-1:0] frame_lat;
   logic                       rev_lat;
   logic [IW-1:0]              issued;
   logic [IW-1:0]              rev_cnt;
   logic [ROW_ADDR_WIDTH-1:0]  row_cur;
   logic                       cur_last;
   logic                       issue, pop, push, flush, launch;

   logic [RD_LATENCY-1:0]      tag_v, tag_last;
   logic [ROW_ADDR_WIDTH-1:0]  tag_row [RD_LATENCY];

   logic [DATA_WIDTH-1:0]      mem_data [FIFO_DEPTH];
   logic [ROW_ADDR_WIDTH-1:0]  mem_idx  [FIFO_DEPTH];
   logic [FIFO_DEPTH-1:0]      mem_last;
   logic [PW-1:0]              wr_ptr, rd_ptr;
   logic [CW-1:0]              occ, inflight;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PTR_MAX) ? '0 : p + PW'(1);
   endfunction

   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + CW'(tag_v[i]);
   end

   assign row_valid = (occ != '0);
   assign pop       = row_valid && row_ready;
   assign push      = tag_v[RD_LATENCY-1];
   assign flush     = abort && (state != IDLE);
   assign launch    = (state == IDLE) && start && !abort;
   assign rev_cnt   = LAST_CNT - issued;
   assign row_cur   = rev_lat ? rev_cnt[ROW_ADDR_WIDTH-1:0] : issued[ROW_ADDR_WIDTH-1:0];
   assign cur_last  = (issued == LAST_CNT);

   // A slot is freed by a pop in the same cycle, so a full FIFO can still keep one read in flight.
   assign issue        = (state == RUN) && !abort && ((occ + inflight - CW'(pop)) < DEPTH_C);
   assign bram_rd_en   = issue;
   assign bram_rd_addr = issue ? {frame_lat, row_cur} : '0;

   assign row_idx  = row_valid ? mem_idx[rd_ptr]  : '0;
   assign row_data = row_valid ? mem_data[rd_ptr] : '0;
   assign row_last = row_valid && mem_last[rd_ptr];

   // done and the drop of busy coincide with acceptance of the final beat, while still in DRAIN.
   assign done = (state == DRAIN) && !abort && pop && row_last;
   assign busy = (state != IDLE) && !done;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (launch) state_nxt = RUN;
         RUN:     if (abort) state_nxt = IDLE;
                  else if (issue && cur_last) state_nxt = DRAIN;
         DRAIN:   if (abort) state_nxt = IDLE;
                  else if (pop && row_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_lat <= '0;
         rev_lat   <= 1'b0;
         issued    <= '0;
      end else begin
         state <= state_nxt;
         if (launch) begin
            frame_lat <= frame_sel;
            rev_lat   <= reverse;
            issued    <= '0;
         end else if (issue) begin
            issued <= issued + IW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tag_v    <= '0;
         tag_last <= '0;
         for (int i = 0; i < RD_LATENCY; i++) tag_row[i] <= '0;
      end else if (flush) begin
         tag_v <= '0;
      end else begin
         tag_v[0]    <= issue;
         tag_last[0] <= cur_last;
         tag_row[0]  <= row_cur;
         for (int i = 1; i < RD_LATENCY; i++) begin
            tag_v[i]    <= tag_v[i-1];
            tag_last[i] <= tag_last[i-1];
            tag_row[i]  <= tag_row[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         occ    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         occ <= occ + CW'(push) - CW'(pop);
      end
   end

   // Payload storage needs no reset; occupancy alone decides what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem_data[wr_ptr] <= bram_rd_data;
         mem_idx[wr_ptr]  <= tag_row[RD_LATENCY-1];
         mem_last[wr_ptr] <= tag_last[RD_LATENCY-1];
      end
   end

endmodule
